// File: rtl/ysyx_23060191_pkg.sv
// Shared definitions for the NPC writeback path.
// Datapath and port widths, writeback FSM state encoding, small helpers.
// Imported by the writeback controller and its retire counter.
package ysyx_23060191_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int RF_ADDR_W  = 5;
  localparam int CSR_ADDR_W = 12;
  localparam int INSTRET_W  = 64;

  // Writeback FSM encoding; the fourth code is never entered and behaves as IDLE.
  localparam logic [1:0] WB_IDLE     = 2'd0;
  localparam logic [1:0] WB_WAIT_LSU = 2'd1;
  localparam logic [1:0] WB_COMMIT   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = WB_IDLE,
    S_WAIT_LSU = WB_WAIT_LSU,
    S_COMMIT   = WB_COMMIT
  } wb_state_e;

  // x0 is hardwired to zero, so a write there is dropped at the port.
  function automatic logic gpr_write_allowed(input logic wen, input logic [RF_ADDR_W-1:0] rd);
    return wen && (rd != '0);
  endfunction

endpackage

// File: rtl/ysyx_23060191_instret_cnt.sv
// Retired-instruction counter: 64-bit, wraps to zero after all-ones.
// Latency: count visible the cycle after an enabled edge.
// No backpressure; increments whenever inc_en_i is high at a rising edge.
module ysyx_23060191_instret_cnt
  import ysyx_23060191_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_en_i,
  output logic [INSTRET_W-1:0] cnt_o
);

  logic [INSTRET_W-1:0] cnt_q;
  logic [INSTRET_W-1:0] cnt_d;

  // Next count: natural modulo-2^64 increment when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_en_i) begin
      cnt_d = cnt_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_23060191_wb_ctrl.sv
// Writeback controller: takes one finished instruction from EXU, waits for LSU data on loads, then commits once.
// Latency: non-load commits the cycle after accept; load commits the cycle after lsu_rvalid is taken.
// Backpressure: exu_ready only in IDLE, lsu_rready only in WAIT_LSU; all write-port outputs come from registers.
module ysyx_23060191_wb_ctrl
  import ysyx_23060191_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [CPU_WIDTH-1:0]  exu_res,
  input  logic [RF_ADDR_W-1:0]  exu_rd,
  input  logic                  exu_rd_wen,
  input  logic                  load_en,
  input  logic                  csr_res_en,
  input  logic [CSR_ADDR_W-1:0] csr_addr,
  input  logic [CPU_WIDTH-1:0]  csr_res,
  input  logic                  lsu_rvalid,
  input  logic [CPU_WIDTH-1:0]  lsu_rdata,
  output logic                  lsu_rready,
  output logic                  rf_wen,
  output logic [RF_ADDR_W-1:0]  rf_waddr,
  output logic [CPU_WIDTH-1:0]  rf_wdata,
  output logic                  csr_wen,
  output logic [CSR_ADDR_W-1:0] csr_waddr,
  output logic [CPU_WIDTH-1:0]  csr_wdata,
  output logic                  commit,
  output logic [INSTRET_W-1:0]  instret
);

  wb_state_e state_q;
  wb_state_e state_d;

  logic                  accept;
  logic                  lsu_take;

  logic [RF_ADDR_W-1:0]  rd_q;
  logic                  rd_wen_q;
  logic [CPU_WIDTH-1:0]  rd_data_q;
  logic                  csr_en_q;
  logic [CSR_ADDR_W-1:0] csr_addr_q;
  logic [CPU_WIDTH-1:0]  csr_data_q;

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; handshakes depend on state only, never on inputs.
  always_comb begin
    state_d    = state_q;
    exu_ready  = 1'b0;
    lsu_rready = 1'b0;
    commit     = 1'b0;
    accept     = 1'b0;
    lsu_take   = 1'b0;
    case (state_q)
      S_WAIT_LSU: begin
        lsu_rready = 1'b1;
        if (lsu_rvalid) begin
          lsu_take = 1'b1;
          state_d  = S_COMMIT;
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        // IDLE, and the unused code which is treated identically.
        exu_ready = 1'b1;
        if (exu_valid) begin
          accept  = 1'b1;
          state_d = load_en ? S_WAIT_LSU : S_COMMIT;
        end
      end
    endcase
  end

  // Instruction capture: control/CSR fields at accept, rd data from EXU (non-load) or LSU (load).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
      rd_data_q  <= '0;
      csr_en_q   <= 1'b0;
      csr_addr_q <= '0;
      csr_data_q <= '0;
    end else begin
      if (accept) begin
        rd_q       <= exu_rd;
        rd_wen_q   <= exu_rd_wen;
        csr_en_q   <= csr_res_en;
        csr_addr_q <= csr_addr;
        csr_data_q <= csr_res;
        // A load's ALU result is an address, not rd data; leave the old value until LSU answers.
        if (!load_en) begin
          rd_data_q <= exu_res;
        end
      end
      if (lsu_take) begin
        rd_data_q <= lsu_rdata;
      end
    end
  end

  assign rf_wen    = commit && gpr_write_allowed(rd_wen_q, rd_q);
  assign rf_waddr  = rd_q;
  assign rf_wdata  = rd_data_q;
  assign csr_wen   = commit && csr_en_q;
  assign csr_waddr = csr_addr_q;
  assign csr_wdata = csr_data_q;

  // Count on the edge that enters COMMIT so the new total is visible alongside the commit pulse.
  ysyx_23060191_instret_cnt u_instret (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (state_d == S_COMMIT),
    .cnt_o    (instret)
  );

endmodule
